// File: rtl/fetch_mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// sys_defs : shared definitions for the unified memory port arbiter.
//   NUM_TAGS / TAG_W : memory tag space (tag 0 means "no tag / rejected").
//   bus_cmd_e        : command driven onto the memory port.
//   owner_e          : requester that owns an outstanding tag.
//   grant_e          : per-cycle arbitration result.
//   tag_live()       : true when a tag value names a real transaction.
// -----------------------------------------------------------------------------
package sys_defs;

    localparam int NUM_TAGS = 16;
    localparam int TAG_W    = 4;

    typedef enum logic [1:0] {
        BUS_NONE  = 2'd0,
        BUS_LOAD  = 2'd1,
        BUS_STORE = 2'd2
    } bus_cmd_e;

    typedef enum logic [1:0] {
        OWN_T1  = 2'd0,
        OWN_T2  = 2'd1,
        OWN_LSQ = 2'd2
    } owner_e;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_T1   = 2'd1,
        GNT_T2   = 2'd2,
        GNT_LSQ  = 2'd3
    } grant_e;

    function automatic logic tag_live(input logic [TAG_W-1:0] tag);
        return (tag != {TAG_W{1'b0}});
    endfunction

endpackage

// File: rtl/fetch_mem_arbiter_tag_table.sv
// -----------------------------------------------------------------------------
// mem_tag_table : one entry per memory tag holding {valid, owner, squashed}.
//   clock, reset        : clock and synchronous active-high reset (clears all).
//   i_alloc_en/tag/owner: record a newly accepted load or fetch.
//   i_lookup_tag        : tag currently returning from memory.
//   i_clear_en          : retire the looked-up entry this cycle.
//   i_squash_t1/t2      : mark every valid entry of that thread as squashed.
//   o_lookup_*          : contents of the looked-up entry.
// -----------------------------------------------------------------------------
module mem_tag_table
    import sys_defs::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             i_alloc_en,
    input  logic [TAG_W-1:0] i_alloc_tag,
    input  owner_e           i_alloc_owner,
    input  logic [TAG_W-1:0] i_lookup_tag,
    input  logic             i_clear_en,
    input  logic             i_squash_t1,
    input  logic             i_squash_t2,
    output logic             o_lookup_valid,
    output owner_e           o_lookup_owner,
    output logic             o_lookup_squashed
);

    logic   [NUM_TAGS-1:0] r_valid;
    logic   [NUM_TAGS-1:0] r_squashed;
    owner_e [NUM_TAGS-1:0] r_owner;

    // Table update: clear, then squash, then allocate, so a same-cycle
    // allocate of the tag being retired is the write that survives.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_valid    <= {NUM_TAGS{1'b0}};
            r_squashed <= {NUM_TAGS{1'b0}};
            for (int i = 0; i < NUM_TAGS; i++) begin
                r_owner[i] <= OWN_T1;
            end
        end else begin
            for (int i = 0; i < NUM_TAGS; i++) begin
                if (i_clear_en && (i_lookup_tag == TAG_W'(i))) begin
                    r_valid[i] <= 1'b0;
                end
                if (r_valid[i] &&
                    ((i_squash_t1 && (r_owner[i] == OWN_T1)) ||
                     (i_squash_t2 && (r_owner[i] == OWN_T2)))) begin
                    r_squashed[i] <= 1'b1;
                end
                if (i_alloc_en && (i_alloc_tag == TAG_W'(i))) begin
                    r_valid[i]    <= 1'b1;
                    r_owner[i]    <= i_alloc_owner;
                    r_squashed[i] <= 1'b0;
                end
            end
        end
    end

    assign o_lookup_valid    = r_valid[i_lookup_tag];
    assign o_lookup_owner    = r_owner[i_lookup_tag];
    assign o_lookup_squashed = r_squashed[i_lookup_tag];

endmodule

// File: rtl/fetch_mem_arbiter.sv
// -----------------------------------------------------------------------------
// fetch_mem_arbiter : shares the unified memory port between thread 1 fetch,
// thread 2 fetch and the LSQ. LSQ has priority; the two fetch threads
// alternate through a round-robin pointer. Returning data is routed to the
// tag's owner, with fetch data dropped for a thread that was redirected.
//   Requests   : threadN_fetch_req/addr, threadN_branch_is_taken,
//                lsq_req/is_store/addr/data, is_two_threads.
//   Memory     : proc2mem_command/addr/data out; mem2proc_response/data/tag in.
//   Back-pressure : threadN_structure_hazard_stall, lsq_stall.
//   Return     : threadN_Imem2proc_data/valid, lsq_load_data/valid.
// -----------------------------------------------------------------------------
module fetch_mem_arbiter
    import sys_defs::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             is_two_threads,
    input  logic             thread1_fetch_req,
    input  logic             thread2_fetch_req,
    input  logic [63:0]      thread1_fetch_addr,
    input  logic [63:0]      thread2_fetch_addr,
    input  logic             thread1_branch_is_taken,
    input  logic             thread2_branch_is_taken,
    input  logic             lsq_req,
    input  logic             lsq_is_store,
    input  logic [63:0]      lsq_addr,
    input  logic [63:0]      lsq_data,
    input  logic [TAG_W-1:0] mem2proc_response,
    input  logic [63:0]      mem2proc_data,
    input  logic [TAG_W-1:0] mem2proc_tag,
    output logic [1:0]       proc2mem_command,
    output logic [63:0]      proc2mem_addr,
    output logic [63:0]      proc2mem_data,
    output logic             thread1_structure_hazard_stall,
    output logic             thread2_structure_hazard_stall,
    output logic             lsq_stall,
    output logic [63:0]      thread1_Imem2proc_data,
    output logic [63:0]      thread2_Imem2proc_data,
    output logic             thread1_Imem2proc_valid,
    output logic             thread2_Imem2proc_valid,
    output logic [63:0]      lsq_load_data,
    output logic             lsq_load_valid
);

    logic   r_rr_t2;        // 1: thread 2 wins the next fetch tie
    grant_e w_grant;
    logic   w_t2_req;
    logic   w_t1_elig;
    logic   w_t2_elig;
    logic   w_accept;
    logic   w_alloc_en;
    owner_e w_alloc_owner;
    logic   w_lk_valid;
    owner_e w_lk_owner;
    logic   w_lk_squashed;
    logic   w_ret_hit;

    // Thread 2 is invisible in single-thread mode; a redirecting thread
    // is held off for the cycle of its branch.
    assign w_t2_req  = thread2_fetch_req & is_two_threads;
    assign w_t1_elig = thread1_fetch_req & ~thread1_branch_is_taken;
    assign w_t2_elig = w_t2_req & ~thread2_branch_is_taken;
    assign w_ret_hit = tag_live(mem2proc_tag) & w_lk_valid;

    // Arbitration: LSQ first, then the eligible fetch thread(s).
    always_comb begin
        w_grant = GNT_NONE;
        if (lsq_req) begin
            w_grant = GNT_LSQ;
        end else if (w_t1_elig && w_t2_elig) begin
            w_grant = r_rr_t2 ? GNT_T2 : GNT_T1;
        end else if (w_t1_elig) begin
            w_grant = GNT_T1;
        end else if (w_t2_elig) begin
            w_grant = GNT_T2;
        end else begin
            w_grant = GNT_NONE;
        end
    end

    assign w_accept = (w_grant != GNT_NONE) & tag_live(mem2proc_response);

    // Table allocation: every accepted transaction except stores expects data back.
    always_comb begin
        w_alloc_en    = 1'b0;
        w_alloc_owner = OWN_T1;
        case (w_grant)
            GNT_T1: begin
                w_alloc_en    = w_accept;
                w_alloc_owner = OWN_T1;
            end
            GNT_T2: begin
                w_alloc_en    = w_accept;
                w_alloc_owner = OWN_T2;
            end
            GNT_LSQ: begin
                w_alloc_en    = w_accept & ~lsq_is_store;
                w_alloc_owner = OWN_LSQ;
            end
            default: begin
                w_alloc_en    = 1'b0;
                w_alloc_owner = OWN_T1;
            end
        endcase
    end

    // Round-robin pointer moves away from whichever thread was just served.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_rr_t2 <= 1'b0;
        end else if (w_accept && (w_grant == GNT_T1)) begin
            r_rr_t2 <= 1'b1;
        end else if (w_accept && (w_grant == GNT_T2)) begin
            r_rr_t2 <= 1'b0;
        end else begin
            r_rr_t2 <= r_rr_t2;
        end
    end

    mem_tag_table u_tag_table (
        .clock             (clock),
        .reset             (reset),
        .i_alloc_en        (w_alloc_en),
        .i_alloc_tag       (mem2proc_response),
        .i_alloc_owner     (w_alloc_owner),
        .i_lookup_tag      (mem2proc_tag),
        .i_clear_en        (w_ret_hit),
        .i_squash_t1       (thread1_branch_is_taken),
        .i_squash_t2       (thread2_branch_is_taken),
        .o_lookup_valid    (w_lk_valid),
        .o_lookup_owner    (w_lk_owner),
        .o_lookup_squashed (w_lk_squashed)
    );

    // Memory command, back-pressure and return routing; all quiet in reset.
    always_comb begin
        proc2mem_command               = BUS_NONE;
        proc2mem_addr                  = 64'd0;
        proc2mem_data                  = 64'd0;
        thread1_structure_hazard_stall = 1'b0;
        thread2_structure_hazard_stall = 1'b0;
        lsq_stall                      = 1'b0;
        thread1_Imem2proc_valid        = 1'b0;
        thread2_Imem2proc_valid        = 1'b0;
        lsq_load_valid                 = 1'b0;
        thread1_Imem2proc_data         = 64'd0;
        thread2_Imem2proc_data         = 64'd0;
        lsq_load_data                  = 64'd0;
        if (!reset) begin
            case (w_grant)
                GNT_T1: begin
                    proc2mem_command = BUS_LOAD;
                    proc2mem_addr    = thread1_fetch_addr;
                end
                GNT_T2: begin
                    proc2mem_command = BUS_LOAD;
                    proc2mem_addr    = thread2_fetch_addr;
                end
                GNT_LSQ: begin
                    proc2mem_command = lsq_is_store ? BUS_STORE : BUS_LOAD;
                    proc2mem_addr    = lsq_addr;
                    proc2mem_data    = lsq_is_store ? lsq_data : 64'd0;
                end
                default: begin
                    proc2mem_command = BUS_NONE;
                end
            endcase

            thread1_structure_hazard_stall = thread1_fetch_req &
                                             ~(w_accept & (w_grant == GNT_T1));
            thread2_structure_hazard_stall = w_t2_req &
                                             ~(w_accept & (w_grant == GNT_T2));
            lsq_stall                      = lsq_req & ~w_accept;

            // A squashed entry, or one whose thread redirects right now, is
            // still retired but never presented as valid.
            if (w_ret_hit && !w_lk_squashed) begin
                case (w_lk_owner)
                    OWN_T1: begin
                        thread1_Imem2proc_valid = ~thread1_branch_is_taken;
                        thread1_Imem2proc_data  = thread1_branch_is_taken ? 64'd0 : mem2proc_data;
                    end
                    OWN_T2: begin
                        thread2_Imem2proc_valid = ~thread2_branch_is_taken & is_two_threads;
                        thread2_Imem2proc_data  = (~thread2_branch_is_taken & is_two_threads) ?
                                                  mem2proc_data : 64'd0;
                    end
                    OWN_LSQ: begin
                        lsq_load_valid = 1'b1;
                        lsq_load_data  = mem2proc_data;
                    end
                    default: begin
                        lsq_load_valid = 1'b0;
                    end
                endcase
            end else begin
                lsq_load_valid = 1'b0;
            end
        end else begin
            proc2mem_command = BUS_NONE;
        end
    end

endmodule
